// File: rtl/four_bit_acc_unit_if.sv
// Command/result handshake bundle for the 4-bit accumulator unit.
// The requester holds the master side and the accumulator holds the slave side.
interface four_bit_acc_unit_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] opcode;
   logic [3:0] operand;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] acc;
   logic       carry;
   logic       zero;
   logic       overflow;
   logic [7:0] op_count;

   modport master (
      output in_valid, opcode, operand, out_ready,
      input  in_ready, out_valid, acc, carry, zero, overflow, op_count
   );

   modport slave (
      input  in_valid, opcode, operand, out_ready,
      output in_ready, out_valid, acc, carry, zero, overflow, op_count
   );
endinterface

// File: rtl/four_bit_acc_unit.sv
// 4-bit accumulator ALU with a two-state command/result handshake.
// Every output comes straight from a register, so no input reaches an output combinationally.
module four_bit_acc_unit (
   input  logic                        clk,
   input  logic                        rst,
   four_bit_acc_unit_if.slave          bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_LOAD = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   state_t     state_q;
   logic [3:0] acc_q, acc_d;
   logic       carry_q, carry_d;
   logic       ovf_q, ovf_d;
   logic       zero_q;
   logic [7:0] cnt_q;
   logic       in_ready_q;
   logic       out_valid_q;

   logic [4:0] sum_s;
   logic [4:0] diff_s;

   assign sum_s  = {1'b0, acc_q} + {1'b0, bus.operand};
   // Bit 4 of the zero-extended difference is set exactly when A < B, i.e. the borrow.
   assign diff_s = {1'b0, acc_q} - {1'b0, bus.operand};

   // Next accumulator value and status flags for the presented opcode
   always_comb begin
      acc_d   = acc_q;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (bus.opcode)
         OP_AND:  acc_d = acc_q & bus.operand;
         OP_OR:   acc_d = acc_q | bus.operand;
         OP_XOR:  acc_d = acc_q ^ bus.operand;
         OP_ADD: begin
            acc_d   = sum_s[3:0];
            carry_d = sum_s[4];
            ovf_d   = (acc_q[3] == bus.operand[3]) && (sum_s[3] != acc_q[3]);
         end
         OP_SUB: begin
            acc_d   = diff_s[3:0];
            carry_d = diff_s[4];
            ovf_d   = (acc_q[3] != bus.operand[3]) && (diff_s[3] != acc_q[3]);
         end
         OP_LOAD: acc_d = bus.operand;
         OP_NOT:  acc_d = ~acc_q;
         OP_CLR:  acc_d = 4'h0;
         default: acc_d = acc_q;
      endcase
   end

   // Handshake FSM together with the result, flag and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= 4'h0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b1;
         cnt_q       <= 8'h00;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  acc_q       <= acc_d;
                  carry_q     <= carry_d;
                  ovf_q       <= ovf_d;
                  zero_q      <= (acc_d == 4'h0);
                  cnt_q       <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                  state_q     <= ST_RESP;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q     <= ST_IDLE;
               end
            end
            ST_RESP: begin
               if (bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end else begin
                  state_q     <= ST_RESP;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.acc       = acc_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.op_count  = cnt_q;

endmodule

// File: doc/four_bit_acc_unit.md
FOUR_BIT_ACC_UNIT -- requirements
Module: four_bit_acc_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  command present on opcode/operand.
REQ-004 in_ready  output  1  unit can accept a command.
REQ-005 opcode  input  3  operation select, per REQ-012.
REQ-006 operand  input  4  unsigned 4-bit operand B.
REQ-007 out_valid  output  1  result registers hold a completed result.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 acc  output  4  accumulator value, registered.
REQ-010 carry, zero, overflow  output  1 each  registered status flags.
REQ-011 op_count  output  8  completed-command count, saturating at 0xFF.

Function
REQ-012 Opcodes, with A = acc:
- 000 AND: A & B.
- 001 OR: A | B.
- 010 XOR: A ^ B.
- 011 ADD: A + B.
- 100 SUB: A - B.
- 101 LOAD: B.
- 110 NOT: ~A, operand ignored.
- 111 CLR: 0, operand ignored.
REQ-013 FSM has two states:
- IDLE: in_ready=1, out_valid=0.
- RESP: in_ready=0, out_valid=1.
REQ-014 Accept = in_valid & in_ready, sampled at the rising edge.
- On accept: acc, flags and op_count update at that edge; state goes IDLE->RESP.
REQ-015 Latency: command accepted at edge N gives out_valid=1 and a valid result on acc and the flags from edge N through the handshake.
REQ-016 In RESP, out_ready=1 at an edge returns the FSM to IDLE.
- in_ready rises after that edge.
- Throughput is at most one command per 2 cycles.
REQ-017 In RESP with out_ready=0, the following hold stable indefinitely:
- acc, carry, zero, overflow, op_count and out_valid.
- in_valid and the command inputs are ignored.
REQ-018 In IDLE with in_valid=0, all registers hold.
- out_ready is ignored in IDLE.
REQ-019 ADD: 5-bit sum; acc = sum[3:0]; carry = sum[4].
REQ-020 SUB: acc = (A - B) mod 16; carry = borrow (1 iff A < B unsigned).
REQ-021 overflow (two's-complement signed, 4-bit):
- ADD: 1 iff A[3]==B[3] and result[3]!=A[3].
- SUB: 1 iff A[3]!=B[3] and result[3]!=A[3].
- All other opcodes: 0.
REQ-022 Opcodes other than ADD/SUB clear carry to 0.
REQ-023 zero = 1 iff the new acc equals 4'h0; updated on every accepted command.
REQ-024 op_count increments by 1 per accepted command and holds at 0xFF once reached.
REQ-025 All outputs are driven from registers or from the FSM state decode only; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 at an edge forces, regardless of state:
- state to IDLE;
- acc=4'h0, carry=0, overflow=0, zero=1, op_count=8'h00;
- in_ready=1 and out_valid=0 in the following cycle.
REQ-027 rst takes priority over a simultaneous accept or result handshake; that command is discarded and not counted.
REQ-028 Reset asserted in RESP drops the pending result; no out_valid pulse follows reset.

Verification
REQ-029 Reset:
- Stimulus: rst high 2 cycles, then low.
- Required: acc=0x0, zero=1, carry=0, overflow=0, op_count=0x00, in_ready=1, out_valid=0.
REQ-030 Logic path:
- Stimulus: LOAD 0xC, then AND 0xA, out_ready held 1.
- Required: acc=0xC then 0x8; zero=0; carry=0; op_count=2; out_valid high one cycle per command.
REQ-031 Add boundaries:
- Stimulus: LOAD 0xF, ADD 0x1.
- Required: acc=0x0, carry=1, zero=1, overflow=0.
- Stimulus: LOAD 0x7, ADD 0x1.
- Required: acc=0x8, carry=0, overflow=1.
REQ-032 Subtract boundaries:
- Stimulus: LOAD 0x3, SUB 0x5.
- Required: acc=0xE, carry=1, overflow=0.
- Stimulus: LOAD 0x8, SUB 0x1.
- Required: acc=0x7, carry=0, overflow=1.
REQ-033 Backpressure:
- Stimulus: XOR 0x5 accepted; out_ready=0 for 4 cycles while in_valid=1 with OR 0xF.
- Required: acc, flags and op_count frozen; in_ready=0 throughout; OR accepted only after out_ready=1 and the return to IDLE.
REQ-034 Mid-operation reset and saturation:
- Stimulus: rst asserted while in RESP.
- Required: next cycle in IDLE, acc=0x0, op_count=0x00, no out_valid.
- Stimulus: 300 back-to-back commands.
- Required: op_count=0xFF.
